// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: read-owner tags, FSM states, default widths.
package vram_pkg;

  localparam int AW_DEF = 15;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_CPU
  } tag_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_CPU_ACK
  } state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches always win, CPU gets the port when video is idle.
// state      | meaning
// ST_IDLE    | free to issue a CPU access when no video fetch is present
// ST_CPU_RD  | CPU read in flight, RAM data captured at this cycle's end
// ST_CPU_ACK | cpu_ack pulse; cpu_req ignored
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          starve
);

  localparam int CW = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT + 1);

  state_e        state_q, state_d;
  tag_e          tag_q, tag_d;
  logic [DW-1:0] vid_dout_q, vid_dout_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          starve_q, starve_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          vid_grant, cpu_issue;

  always_comb begin
    vid_grant  = vid_req && !reset;
    cpu_issue  = !vid_req && !reset && (state_q == ST_IDLE) && cpu_req;
    state_d    = state_q;
    tag_d      = TAG_NONE;
    vid_dout_d = vid_dout_q;
    cpu_dout_d = cpu_dout_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_din    = din_q;

    if (vid_grant) begin
      ram_addr = vid_addr;
      tag_d    = TAG_VID;
    end else if (cpu_issue) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      ram_din  = cpu_din;
      if (!cpu_we) tag_d = TAG_CPU;
    end
    // Drive a quiet port while reset is held so no access leaks out
    if (reset) begin
      ram_addr = '0;
      ram_din  = '0;
    end

    case (tag_q)
      TAG_VID: vid_dout_d = ram_dout;
      TAG_CPU: cpu_dout_d = ram_dout;
      default: ;
    endcase

    case (state_q)
      ST_IDLE:    if (cpu_issue) state_d = cpu_we ? ST_CPU_ACK : ST_CPU_RD;
      ST_CPU_RD:  state_d = ST_CPU_ACK;
      ST_CPU_ACK: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (cpu_issue) begin
      wait_d = '0;
    end else if (cpu_req && (state_q == ST_IDLE) && (wait_q != WAIT_SAT)) begin
      wait_d = wait_q + 1'b1;
    end
    if (wait_d == WAIT_SAT) starve_d = 1'b1;

    addr_d  = ram_addr;
    din_d   = ram_din;
    cpu_ack = (state_q == ST_CPU_ACK) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tag_q      <= TAG_NONE;
      vid_dout_q <= '0;
      cpu_dout_q <= '0;
      wait_q     <= '0;
      starve_q   <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      vid_dout_q <= vid_dout_d;
      cpu_dout_q <= cpu_dout_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign vid_dout = vid_dout_q;
  assign cpu_dout = cpu_dout_q;
  assign starve   = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM plus a transaction-level model of
// grant timing, data visibility and starvation, driven by directed and random traffic.
module tb_vram_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_dout;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          starve;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .starve(starve)
  );

  // VRAM: synchronous, one-cycle read latency
  logic [DW-1:0] mem    [0:32767];
  logic [DW-1:0] shadow [0:32767];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Transaction model state
  bit            m_active = 0;
  bit            m_issued = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  logic [DW-1:0] m_rd_data = '0;
  int            m_stall = 0;
  int            m_ack_cyc = -1;
  logic [DW-1:0] e_vid = '0;
  logic [DW-1:0] e_cpu = '0;
  bit            e_starve = 0;
  bit            e_starve_nxt = 0;
  logic [AW-1:0] e_addr = '0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } vfetch_t;
  vfetch_t vq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are already driven; evaluate model and compare at negedge.
  task automatic step();
    bit issue_now;
    bit ack_now;
    @(negedge clk);
    e_starve     = e_starve | e_starve_nxt;
    e_starve_nxt = 0;
    while (vq.size() > 0 && vq[0].due == cyc) begin
      e_vid = vq[0].data;
      void'(vq.pop_front());
    end
    ack_now = m_active && m_issued && (cyc == m_ack_cyc);
    if (ack_now && !m_we) e_cpu = m_rd_data;

    if (reset) begin
      check_eq("rst_ack", {31'd0, cpu_ack}, 32'd0);
      check_eq("rst_we", {31'd0, ram_we}, 32'd0);
      e_vid = '0; e_cpu = '0; e_starve = 0; e_starve_nxt = 0; e_addr = '0;
      vq.delete();
      m_active = 0;
    end else begin
      check_eq("vid_dout", {24'd0, vid_dout}, {24'd0, e_vid});
      check_eq("cpu_dout", {24'd0, cpu_dout}, {24'd0, e_cpu});
      check_eq("starve", {31'd0, starve}, {31'd0, e_starve});
      check_eq("cpu_ack", {31'd0, cpu_ack}, {31'd0, ack_now});
      issue_now = 0;
      if (m_active && !m_issued) begin
        if (vid_req) begin
          m_stall++;
          if (m_stall > MAX_WAIT) e_starve_nxt = 1;
        end else begin
          issue_now = 1;
        end
      end
      if (vid_req) begin
        e_addr = vid_addr;
        vq.push_back('{due: cyc + 2, data: shadow[vid_addr]});
      end else if (issue_now) begin
        e_addr    = m_addr;
        m_issued  = 1;
        m_ack_cyc = cyc + (m_we ? 1 : 2);
        if (m_we) shadow[m_addr] = m_din;
        else m_rd_data = shadow[m_addr];
      end
      check_eq("ram_we", {31'd0, ram_we}, {31'd0, (issue_now && m_we)});
      check_eq("ram_addr", {17'd0, ram_addr}, {17'd0, e_addr});
      if (issue_now && m_we) check_eq("ram_din", {24'd0, ram_din}, {24'd0, m_din});
      if (ack_now) m_active = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_cycle();
    step();
    if (!m_active) cpu_req = 1'b0;
  endtask

  task automatic start_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    m_active = 1; m_issued = 0; m_we = we; m_addr = a; m_din = d; m_stall = 0;
  endtask

  task automatic wait_cpu(input int budget);
    int n;
    n = 0;
    while (m_active && n < budget) begin
      run_cycle();
      n++;
    end
    check_eq("cpu_done", {31'd0, m_active}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      shadow[i] = mem[i];
    end
    mem[16]    = 8'h3C;
    shadow[16] = 8'h3C;

    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    run_cycle();
    run_cycle();
    reset = 1'b0;
    run_cycle();

    // Write then read, no video
    start_cpu(1'b1, 15'h1234, 8'hA5);
    wait_cpu(6);
    start_cpu(1'b0, 15'h1234, 8'h00);
    wait_cpu(6);
    check_eq("wr_rd_a5", {24'd0, cpu_dout}, 32'h0000_00A5);

    // Collision in IDLE: video wins, CPU retried next cycle
    vid_req = 1'b1; vid_addr = 15'h0010;
    start_cpu(1'b0, 15'h0040, 8'h00);
    run_cycle();
    vid_req = 1'b0;
    wait_cpu(6);
    check_eq("collide_vid", {24'd0, vid_dout}, 32'h0000_003C);

    // Video fetch during CPU_RD
    start_cpu(1'b0, 15'h0020, 8'h00);
    run_cycle();
    vid_req = 1'b1; vid_addr = 15'h0030;
    run_cycle();
    vid_req = 1'b0;
    wait_cpu(6);
    run_cycle();
    check_eq("rd_vid_cpu", {24'd0, cpu_dout}, {24'd0, shadow[15'h0020]});
    check_eq("rd_vid_vid", {24'd0, vid_dout}, {24'd0, shadow[15'h0030]});

    // Scan-out: fetch every 8 cycles with continuous CPU writes
    for (int i = 0; i < 400; i++) begin
      vid_req  = (i % 8 == 0);
      vid_addr = 15'($urandom_range(0, 63));
      if (!m_active) start_cpu(1'b1, 15'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      run_cycle();
    end
    vid_req = 1'b0;
    wait_cpu(6);

    // Random mixed traffic
    for (int i = 0; i < 2000; i++) begin
      vid_req  = ($urandom_range(0, 99) < 25);
      vid_addr = 15'($urandom_range(0, 63));
      if (!m_active && $urandom_range(0, 99) < 70)
        start_cpu(1'($urandom_range(0, 1)), 15'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      run_cycle();
    end
    vid_req = 1'b0;
    wait_cpu(6);

    // Starvation: nine back-to-back fetches against a pending CPU read
    start_cpu(1'b0, 15'h0005, 8'h00);
    for (int i = 0; i < 9; i++) begin
      vid_req  = 1'b1;
      vid_addr = 15'($urandom_range(0, 63));
      run_cycle();
    end
    vid_req = 1'b0;
    wait_cpu(6);
    run_cycle();
    check_eq("starve_sticky", {31'd0, starve}, 32'd1);

    // Reset in the CPU_RD cycle abandons the read
    start_cpu(1'b0, 15'h1234, 8'h00);
    run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    check_eq("post_rst_starve", {31'd0, starve}, 32'd0);
    check_eq("post_rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
    run_cycle();
    run_cycle();
    start_cpu(1'b0, 15'h1234, 8'h00);
    wait_cpu(6);
    check_eq("post_rst_read", {24'd0, cpu_dout}, 32'h0000_00A5);
    run_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (32K x 8, 1-cycle read latency) between the scan-out video block and the 68k CPU bus.
- Video fetches have absolute priority and fixed latency, so scan-out never tears.
- CPU reads and writes use a req/ack handshake and are stalled only by colliding video fetches.
- Sits between the video block, the CPU bus glue and the VRAM instance.

Parameters:
- AW, 15, RAM address width
- DW, 8, RAM data width
- MAX_WAIT, 8, CPU wait cycles before the sticky starvation flag sets

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- vid_req  in  1  video fetch strobe, one cycle per fetch
- vid_addr  in  AW  video fetch address, valid with vid_req
- vid_dout  out  DW  last video fetch data, held until next fetch
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  AW  CPU address; stable while cpu_req
- cpu_din  in  DW  CPU write data; stable while cpu_req
- cpu_dout  out  DW  CPU read data, valid in the cpu_ack cycle, held afterwards
- cpu_ack  out  1  one-cycle completion pulse
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, valid one cycle after the address cycle
- starve  out  1  sticky: a CPU request waited more than MAX_WAIT cycles

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-high (reset).

Reset:
- State=IDLE; read-tag pipeline cleared.
- vid_dout=0, cpu_dout=0, cpu_ack=0, starve=0, wait counter=0.
- ram_we=0, ram_addr=0, ram_din=0.
- Reset mid-access abandons it: no ack is issued and no write is completed after reset is seen.

Port grant (combinational, per cycle):
- vid_req=1 -> video owns the port: ram_addr=vid_addr, ram_we=0. This applies in every state.
- Else if state==IDLE and cpu_req=1 -> CPU issue: ram_addr=cpu_addr, ram_we=cpu_we, ram_din=cpu_din.
- Else idle port: ram_we=0, ram_addr holds its last value.

Read-tag pipeline:
- One-stage register, tag in {NONE, VID, CPU}, written with the owner of each read issued.
- Next cycle: tag VID -> vid_dout <= ram_dout; tag CPU -> cpu_dout <= ram_dout.
- Video latency: vid_req at cycle t -> vid_dout updated at edge t+2, stable until the next video fetch.

FSM (IDLE, CPU_RD, CPU_ACK):
- IDLE: on a CPU issue with cpu_we=1 -> CPU_ACK; the write happens in the issue cycle. On a CPU issue with cpu_we=0 -> CPU_RD, tag=CPU.
- CPU_RD: data is captured into cpu_dout at this cycle's end edge -> CPU_ACK. A vid_req here is granted normally, because the port is free.
- CPU_ACK: cpu_ack=1 for exactly this cycle; cpu_req is ignored this cycle -> IDLE. The CPU must drop or renew cpu_req after seeing cpu_ack.
- Latency with no collision: write 2 cycles req->ack; read 3 cycles req->ack.

Collisions:
- vid_req and cpu_req in the same IDLE cycle -> video wins; the CPU stays pending and is retried next cycle.
- Back-to-back vid_req stalls the CPU indefinitely. The wait counter counts only cycles with cpu_req=1 && state==IDLE && no issue.
- Counter saturates at MAX_WAIT+1; reaching MAX_WAIT+1 sets starve, which clears only on reset. The counter clears on any CPU issue.

Other rules:
- Address arithmetic: none; addresses are passed through unmodified.
- Write data is never visible on cpu_dout.

Decomposition:
- Package vram_pkg holds: the tag enum (NONE, VID, CPU); the state enum (IDLE, CPU_RD, CPU_ACK); AW/DW defaults.
- No sub-module. The wait counter and the tag register stay inline.

Test Plan:
- Write then read, no video: cpu write addr 0x1234 data 0xA5 -> ram_we at t0, ack at t1; read 0x1234 -> cpu_ack at t+2 with cpu_dout=0xA5.
- Collision: vid_req and cpu read in the same cycle, vid_addr=0x0010 (RAM 0x3C) -> vid_dout=0x3C at t+2; CPU issued at t+1, ack at t+3.
- Video during CPU_RD: vid_req in the cycle after a CPU read issue -> cpu_dout gets the CPU data and vid_dout gets the video data, with no cross-contamination.
- Starvation: cpu_req held with vid_req=1 for 9 consecutive cycles (MAX_WAIT=8) -> starve=1 after the 9th; remains 1 after the CPU completes.
- Reset mid-read: assert reset in the CPU_RD cycle -> no cpu_ack; all outputs 0 next cycle; a fresh request after reset completes normally.
- Scan-out pattern: vid_req every 8 cycles with continuous CPU writes -> every video fetch returns correct data at t+2, and every CPU write is acked within 3 cycles.
